seq_divider_8bit: RTL
=====================

Name: seq_divider_8bit

Overview:
- Sequential unsigned integer divider. It is the inverse-operation companion to the team's combinational 8-bit adder/subtractor.
- Uses non-restoring division: one add-or-subtract of the partial remainder per clock, with the add/subtract choice made by the sign of the previous partial remainder.
- Sits beside the adder/subtractor in the arithmetic collection.
- Accepts a Start pulse. Returns Quotient and Remainder with a one-cycle Done pulse.

Parameters:
- WIDTH, 8, operand width in bits (Dividend, Divisor, Quotient, Remainder); iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only when FSM is IDLE
- Dividend  input  WIDTH  numerator, latched on accepted Start
- Divisor  input  WIDTH  denominator, latched on accepted Start
- Quotient  output  WIDTH  registered result
- Remainder  output  WIDTH  registered result
- Busy  output  1  high in CALC and FIX
- Done  output  1  single-cycle pulse; results valid from this cycle
- DivByZero  output  1  registered flag, valid with Done

Behaviour:
- Reset: rst_n low asynchronously forces:
  - FSM = IDLE, iteration counter = 0
  - Quotient = 0, Remainder = 0
  - Busy = 0, Done = 0, DivByZero = 0
  - Internal R/Q/D registers = 0
- Reset mid-operation: the operation is abandoned and no Done is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE, Start=1, Divisor!=0:
  - Latch D = Divisor, Q = Dividend, R = 0 (R is WIDTH+1 bits, signed).
  - Counter = 0; go to CALC; DivByZero <= 0.
- IDLE, Start=1, Divisor==0:
  - Stay IDLE. At the same edge: Quotient <= all ones, Remainder <= Dividend, DivByZero <= 1, Done <= 1.
  - Latency is 1 cycle.
- CALC, each edge:
  - {R,Q} shifted left by 1.
  - If the old R sign bit = 0, R <= shifted R - D; otherwise R <= shifted R + D. D is zero-extended to WIDTH+1.
  - Q[0] <= ~new R sign bit.
  - Counter increments. After the WIDTH-th iteration, go to FIX.
- FIX, one edge:
  - If R is negative, R <= R + D.
  - Quotient <= Q, Remainder <= R[WIDTH-1:0], Done <= 1, go to IDLE.
- Latency: Start sampled at edge k gives Done high after edge k+WIDTH+1 (edge k+9 for WIDTH=8). Throughput is one division per WIDTH+1 cycles.
- Done is high exactly one cycle and is cleared on the next edge.
- Quotient, Remainder and DivByZero hold their values until the next result is written.
- Start while Busy is ignored entirely: no latch, no restart, no queuing.
- Start in the same cycle as Done (FSM already IDLE) is accepted, giving back-to-back operation.
- Operand inputs are don't-care except in the cycle Start is accepted.
- All arithmetic is unsigned. The invariant Dividend = Quotient*Divisor + Remainder with Remainder < Divisor holds for every nonzero Divisor.

Decomposition:
- Shared include file holds:
  - FSM state localparams (IDLE=2'd0, CALC=2'd1, FIX=2'd2)
  - Counter width localparam (clog2(WIDTH)+1)
- One natural sub-module: addsub_stage, a WIDTH+1-bit combinational add/subtract.
  - Op=1 subtracts via B XOR Op with carry-in Op, matching the team's adder/subtractor structure.
  - Instantiated once and shared by CALC and FIX.
- FSM, counter and output registers live in the top module.

Test Plan:
- Dividend=100, Divisor=7, Start at edge k -> Done after edge k+9, Quotient=14, Remainder=2, DivByZero=0; Busy high for exactly 9 cycles.
- 255/1 -> Quotient=255, Remainder=0. Then 5/9 -> Quotient=0, Remainder=5. Then 255/255 -> Quotient=1, Remainder=0.
- 200/0 -> Done one cycle after Start, Quotient=8'hFF, Remainder=200, DivByZero=1, Busy never asserts.
- Start 100/7, then pulse Start with 50/5 during CALC -> only one Done, with result 14 r 2. Next, issue Start 50/5 in the Done cycle -> second Done 9 cycles later with 10 r 0.
- Start 100/7, drop rst_n at cycle 4 -> all outputs 0 immediately, no Done. After release, 81/9 -> 9 r 0.
- Random sweep: 2000 operand pairs plus exhaustive Divisor in {0,1,2,255} -> each result matches the reference model, and the invariant holds for every nonzero Divisor.

Source files
------------

// File: rtl/seq_divider_8bit_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_8bit_pkg
// Shared definitions for the sequential non-restoring divider:
//   - state_t      : FSM state encoding (IDLE=0, CALC=1, FIX=2)
//   - cnt_width()  : width of the iteration counter for a given operand width
//   - DEFAULT_WIDTH: default operand width
// -----------------------------------------------------------------------------
package seq_divider_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Counter must hold values 0..WIDTH-1 with headroom for the increment.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_8bit_addsub_stage.sv
// -----------------------------------------------------------------------------
// seq_divider_8bit_addsub_stage
// Combinational W-bit add/subtract, built like the team adder/subtractor:
// B is XORed with Op and Op is fed in as the carry, so Op=1 gives A-B and
// Op=0 gives A+B (both modulo 2^W).
// Ports:
//   i_a   [W-1:0] first operand
//   i_b   [W-1:0] second operand
//   i_op          0 = add, 1 = subtract
//   o_sum [W-1:0] result, carry-out discarded
// -----------------------------------------------------------------------------
module seq_divider_8bit_addsub_stage #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_op,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] w_b_x;

    assign w_b_x = i_b ^ {W{i_op}};
    assign o_sum = i_a + w_b_x + {{(W-1){1'b0}}, i_op};

endmodule

// File: rtl/seq_divider_8bit.sv
// -----------------------------------------------------------------------------
// seq_divider_8bit
// Sequential unsigned divider using non-restoring division: one add-or-subtract
// of the partial remainder per clock, WIDTH iterations, then one fix-up cycle.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   Start        request, sampled only in IDLE
//   Dividend     numerator, latched when Start is accepted
//   Divisor      denominator, latched when Start is accepted
//   Quotient     registered quotient
//   Remainder    registered remainder
//   Busy         high while in CALC or FIX
//   Done         one-cycle pulse, results valid from this cycle
//   DivByZero    registered flag, valid with Done
//   o_dbg_state  current FSM state (debug observation)
//
// Handshake: Start is accepted on any rising edge where the FSM is IDLE
// (Busy low, which includes the Done cycle). Start while Busy is dropped
// without effect. Each accepted Start produces exactly one Done pulse, after
// 1 cycle for a zero divisor and after WIDTH+1 cycles otherwise, unless reset
// intervenes.
// -----------------------------------------------------------------------------
module seq_divider_8bit
    import seq_divider_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [1:0]       o_dbg_state
);

    localparam int                CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // FSM
    state_t r_state;
    state_t w_state_nxt;

    // Control strobes decoded from the state
    logic w_load;
    logic w_zero;
    logic w_calc;
    logic w_fix;

    // Datapath registers. r_r is a WIDTH+1-bit two's-complement partial
    // remainder; its MSB is the sign that steers the next add/subtract.
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;

    // Output registers
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_done;
    logic             r_dz;

    // Shared add/subtract stage
    logic [WIDTH:0] w_shift_r;
    logic [WIDTH:0] w_add_a;
    logic [WIDTH:0] w_add_b;
    logic           w_add_op;
    logic [WIDTH:0] w_sum;
    logic [WIDTH-1:0] w_rem_fix;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_zero      = 1'b0;
        w_calc      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (Divisor == '0) begin
                        // Answer immediately without entering the iteration.
                        w_zero = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                w_calc = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Add/subtract operand selection.
    // CALC: shift {R,Q} left and subtract D if the old R was non-negative,
    //       otherwise add D.
    // FIX : add D back to correct a negative final remainder.
    // The true partial remainder always lies in [-D, D), which fits in
    // WIDTH+1 signed bits, so dropping the old sign bit when shifting and
    // letting the adder wrap still yields the exact result.
    // ------------------------------------------------------------------
    assign w_shift_r = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_add_a   = (r_state == FIX) ? r_r : w_shift_r;
    assign w_add_b   = {1'b0, r_d};
    assign w_add_op  = (r_state == FIX) ? 1'b0 : ~r_r[WIDTH];

    seq_divider_8bit_addsub_stage #(
        .W (WIDTH + 1)
    ) u_addsub (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_op  (w_add_op),
        .o_sum (w_sum)
    );

    assign w_rem_fix = r_r[WIDTH] ? w_sum[WIDTH-1:0] : r_r[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_r    <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_load) begin
                r_d   <= Divisor;
                r_q   <= Dividend;
                r_r   <= '0;
                r_cnt <= '0;
                r_dz  <= 1'b0;
            end

            if (w_zero) begin
                r_quot <= '1;
                r_rem  <= Dividend;
                r_dz   <= 1'b1;
                r_done <= 1'b1;
            end

            if (w_calc) begin
                r_r   <= w_sum;
                // New quotient bit is 1 when the new remainder is non-negative.
                r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_fix) begin
                r_quot <= r_q;
                r_rem  <= w_rem_fix;
                r_done <= 1'b1;
                r_cnt  <= '0;
            end
        end
    end

    assign Quotient    = r_quot;
    assign Remainder   = r_rem;
    assign Done        = r_done;
    assign DivByZero   = r_dz;
    assign Busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule
